// File: rtl/mult_div_unit_if.sv
// EX-stage multiply/divide port bundle: forwarded operands and op select in,
// busy/stall and architectural HI/LO out.
interface mult_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  mdctr;
  logic        flush;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output A, B, mdctr, flush,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  A, B, mdctr, flush,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu unit holding the HI/LO registers.
// Operands are captured at issue and the result is committed after a fixed latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV
  } state_e;

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES);

  state_e        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic          sgn_q, sgn_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;

  // Arithmetic datapath on the captured operands
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, dvs, uq, ur, quo, rem;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    abs_a  = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    abs_b  = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Substitute a divisor of 1 for zero so the datapath never goes undefined;
    // the result is discarded in that case anyway.
    dvs    = (b_q == '0) ? 32'd1 : abs_b;
    uq     = abs_a / dvs;
    ur     = abs_a % dvs;
    // Magnitude divide then sign fix-up; 0x80000000 / -1 wraps back to 0x80000000.
    quo    = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    rem    = (sgn_q && a_q[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    a_n     = a_q;
    b_n     = b_q;
    sgn_n   = sgn_q;
    hi_n    = hi_q;
    lo_n    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (!md.flush) begin
          case (md_op_e'(md.mdctr))
            OP_MULT, OP_MULTU: begin
              state_n = S_MULT;
              cnt_n   = CW'(1);
              a_n     = md.A;
              b_n     = md.B;
              sgn_n   = (md_op_e'(md.mdctr) == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_n = S_DIV;
              cnt_n   = CW'(1);
              a_n     = md.A;
              b_n     = md.B;
              sgn_n   = (md_op_e'(md.mdctr) == OP_DIV);
            end
            OP_MTHI: hi_n = md.A;
            OP_MTLO: lo_n = md.A;
            default: ;
          endcase
        end
      end

      S_MULT: begin
        if (cnt_q == MULT_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          if (sgn_q) {hi_n, lo_n} = prod_s;
          else       {hi_n, lo_n} = prod_u;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      S_DIV: begin
        if (cnt_q == DIV_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          if (b_q != '0) begin
            hi_n = rem;
            lo_n = quo;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      sgn_q   <= sgn_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  assign md.busy  = (state_q != S_IDLE);
  assign md.stall = md.busy | ((md.mdctr >= 3'd1) && (md.mdctr <= 3'd4) && !md.flush);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule
